simd_alu_pipe: RTL and testbench
================================

Name: simd_alu_pipe

Overview:
- Multi-lane, pipelined successor to the single-lane combinational ALU in the warp datapath.
- Executes one warp_pkg::alu_opcode_e operation across NUM_LANES lanes per accepted beat.
- Fixed two-stage pipeline with valid/ready handshake on both sides, per-lane masking and per-lane sticky overflow flags.
- Sits between the operand-collect stage and register-file writeback.

Parameters:
- DATA_WIDTH, warp_pkg::DATA_WIDTH (32), lane operand/result width in bits
- NUM_LANES, 4, number of parallel lanes (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_opcode  in  alu_opcode_e  operation for all lanes of the beat
- in_lane_mask  in  NUM_LANES  1 = lane active
- in_op1, in_op2, in_op3  in  NUM_LANES*DATA_WIDTH  packed lane operands; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_result  out  NUM_LANES*DATA_WIDTH  packed lane results
- out_overflow  out  NUM_LANES  per-lane overflow of this beat
- out_lane_mask  out  NUM_LANES  mask carried with the beat
- ovf_sticky  out  NUM_LANES  per-lane OR of out_overflow over all delivered beats
- clr_sticky  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (rst_n low, async): S1/S2 valid = 0; out_valid = 0; out_result = 0; out_overflow = 0; out_lane_mask = 0; ovf_sticky = 0. in_ready goes high once reset is deasserted. A beat in flight when reset asserts is dropped.
- Pipeline stages:
  - S1 registers opcode, mask, op3 and the 2*DATA_WIDTH signed products op1*op2 per lane.
  - S2 registers the final result and overflow.
- Latency: 2 cycles from accept (in_valid && in_ready) to out_valid, with no stalls.
- Throughput: 1 beat per cycle.
- Stall rules:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or S2 is being consumed.
  - in_ready = !S1_valid || S1_advances (combinational from out_ready; no skid).
- Output stability: out_* are stable while out_valid && !out_ready.
- Per-lane arithmetic (signed two's complement, results truncated to DATA_WIDTH):
  - ADD: op1+op2. ovf = operand signs equal and result sign differs.
  - MUL: low half of product. ovf = upper DATA_WIDTH bits != replication of result MSB.
  - FMA: low(op1*op2)+op3. ovf = mul ovf (as MUL) OR add ovf (as ADD on low product and op3).
  - MAX: signed max(op1,op2). ovf = 0.
  - RELU: op1 if MSB = 0, else 0. ovf = 0.
  - Any other opcode: result 0, ovf 0.
- Masked lanes (mask bit 0): result 0, ovf 0, no sticky update.
- ovf_sticky[i] sets on the cycle a beat is delivered (out_valid && out_ready) with out_overflow[i] = 1.
- clr_sticky clears ovf_sticky. If a delivery with overflow occurs in the same cycle, set wins (flag reads 1 next cycle).

Optional Feature:
- Macro SIMD_ALU_SAT_EN.
- When defined: any lane with ovf = 1 outputs a saturated result instead of the wrapped value.
  - Value: max positive (0x7FFF_FFFF at W=32) or min negative (0x8000_0000).
  - Direction: sign of the exact mathematical result (ADD: DATA_WIDTH+1 bits; MUL: full product; FMA: full product + sign-extended op3 in 2*DATA_WIDTH+1 bits).
  - out_overflow and ovf_sticky still report the event.
- When undefined: wrapped results only; no saturation logic is synthesised.

Test Plan:
- ADD, all lanes, op1 = 0x7FFF_FFFF, op2 = 1: beat appears 2 cycles after accept.
  - Without macro: result 0x8000_0000, ovf = 1111.
  - With macro: result 0x7FFF_FFFF.
- MUL, lane0 = 0x0001_0000 * 0x0001_0000; lane1 = -3 * 4 (0xFFFF_FFFD, 4):
  - lane0: result 0, ovf = 1.
  - lane1: result 0xFFFF_FFF4, ovf = 0.
- FMA 0x4000_0000*2 + 0 -> result 0x8000_0000, ovf = 1 (wrapped); with macro result 0x7FFF_FFFF. FMA 3*5 + (-20) -> 0xFFFF_FFFB, ovf = 0.
- Back-to-back stream of 6 beats with out_ready low for cycles 3-5:
  - in_ready drops once S1 and S2 are full.
  - No beat is lost or duplicated; order is preserved; out_* are stable during the stall.
- Mask 0101, MAX with (-1, -5) in every lane -> lanes 0 and 2 give 0xFFFF_FFFF; lanes 1 and 3 give 0, ovf 0.
- Sticky and reset:
  - Deliver an overflow beat on lane2 -> ovf_sticky = 0100.
  - Pulse clr_sticky alone -> 0000.
  - Assert rst_n low mid-stall -> out_valid = 0 immediately; no output after release.

Source files
------------

// File: rtl/simd_alu_pipe.sv
// Purpose : NUM_LANES-wide signed ALU (ADD/MUL/FMA/MAX/RELU) with lane mask and sticky per-lane overflow.
// Latency : 2 cycles accept-to-out_valid, 1 beat/cycle throughput.
// Backpres: S2 holds while out_valid && !out_ready; in_ready = !s1_vld || S1 advances (no skid buffer).
//
// Ports   : clk/rst_n (async active-low); in_valid/in_ready/in_opcode/in_lane_mask/in_op1..3 input beat;
//           out_valid/out_ready/out_result/out_overflow/out_lane_mask result beat;
//           ovf_sticky/clr_sticky accumulated per-lane overflow and its synchronous clear.
// Option  : define SIMD_ALU_SAT_EN to saturate overflowed lanes instead of wrapping.

package warp_pkg;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_MUL  = 3'd1,
      ALU_FMA  = 3'd2,
      ALU_MAX  = 3'd3,
      ALU_RELU = 3'd4,
      ALU_NOP  = 3'd7
   } alu_opcode_e;
endpackage

module simd_alu_pipe
   import warp_pkg::*;
#(
   parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
   parameter int NUM_LANES  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  alu_opcode_e                     in_opcode,
   input  logic [NUM_LANES-1:0]            in_lane_mask,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_op1,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_op2,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_op3,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_LANES*DATA_WIDTH-1:0] out_result,
   output logic [NUM_LANES-1:0]            out_overflow,
   output logic [NUM_LANES-1:0]            out_lane_mask,
   output logic [NUM_LANES-1:0]            ovf_sticky,
   input  logic                            clr_sticky
);

   localparam int W = DATA_WIDTH;
   localparam int L = NUM_LANES;

   // Returns {ovf, result} for one lane; p is the full signed product a*b.
   function automatic logic [W:0] lane_eval(input alu_opcode_e op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] c,
                                            input logic [2*W-1:0] p);
      logic [W-1:0] res;
      logic         ovf;
      logic         mul_ovf;
      res     = '0;
      ovf     = 1'b0;
      // Product fits in W bits only if the upper half is pure sign extension.
      mul_ovf = (p[2*W-1:W] != {W{p[W-1]}});
      case (op)
         ALU_ADD: begin
            res = a + b;
            ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
         end
         ALU_MUL: begin
            res = p[W-1:0];
            ovf = mul_ovf;
         end
         ALU_FMA: begin
            res = p[W-1:0] + c;
            ovf = mul_ovf || ((p[W-1] == c[W-1]) && (res[W-1] != p[W-1]));
         end
         ALU_MAX:  res = ($signed(a) > $signed(b)) ? a : b;
         ALU_RELU: res = a[W-1] ? '0 : a;
         default: ;
      endcase
`ifdef SIMD_ALU_SAT_EN
      begin
         // Saturation direction follows the sign of the exact, unwrapped result.
         logic         neg;
         logic [W:0]   add_x;
         logic [2*W:0] fma_x;
         add_x = {a[W-1], a} + {b[W-1], b};
         fma_x = {p[2*W-1], p} + {{(W+1){c[W-1]}}, c};
         case (op)
            ALU_ADD: neg = add_x[W];
            ALU_MUL: neg = p[2*W-1];
            ALU_FMA: neg = fma_x[2*W];
            default: neg = 1'b0;
         endcase
         if (ovf) begin
            res = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         end
      end
`endif
      return {ovf, res};
   endfunction

   // Stage 1 state
   logic                     s1_vld_q,  s1_vld_d;
   alu_opcode_e              s1_op_q,   s1_op_d;
   logic [L-1:0]             s1_mask_q, s1_mask_d;
   logic [L*W-1:0]           s1_op1_q,  s1_op1_d;
   logic [L*W-1:0]           s1_op2_q,  s1_op2_d;
   logic [L*W-1:0]           s1_op3_q,  s1_op3_d;
   logic [L-1:0][2*W-1:0]    s1_prod_q, s1_prod_d;

   // Stage 2 state (drives the outputs directly)
   logic                     s2_vld_q,  s2_vld_d;
   logic [L*W-1:0]           s2_res_q,  s2_res_d;
   logic [L-1:0]             s2_ovf_q,  s2_ovf_d;
   logic [L-1:0]             s2_mask_q, s2_mask_d;
   logic [L-1:0]             sticky_q,  sticky_d;

   logic                     s1_adv;
   logic [W:0]               lane_out;

   // Stage 1: accept a beat and form the full-width signed products.
   always_comb begin
      s1_adv    = !s2_vld_q || out_ready;
      in_ready  = !s1_vld_q || s1_adv;
      s1_vld_d  = s1_vld_q;
      s1_op_d   = s1_op_q;
      s1_mask_d = s1_mask_q;
      s1_op1_d  = s1_op1_q;
      s1_op2_d  = s1_op2_q;
      s1_op3_d  = s1_op3_q;
      s1_prod_d = s1_prod_q;
      if (in_ready) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_op_d   = in_opcode;
            s1_mask_d = in_lane_mask;
            s1_op1_d  = in_op1;
            s1_op2_d  = in_op2;
            s1_op3_d  = in_op3;
            for (int i = 0; i < L; i++) begin
               s1_prod_d[i] = $signed({{W{in_op1[i*W+W-1]}}, in_op1[i*W +: W]}) *
                              $signed({{W{in_op2[i*W+W-1]}}, in_op2[i*W +: W]});
            end
         end
      end
   end

   // Stage 2: finish per-lane result/overflow and apply the lane mask.
   always_comb begin
      s2_vld_d  = s2_vld_q;
      s2_res_d  = s2_res_q;
      s2_ovf_d  = s2_ovf_q;
      s2_mask_d = s2_mask_q;
      lane_out  = '0;
      if (s1_adv) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_mask_d = s1_mask_q;
            for (int i = 0; i < L; i++) begin
               lane_out = lane_eval(s1_op_q, s1_op1_q[i*W +: W], s1_op2_q[i*W +: W],
                                    s1_op3_q[i*W +: W], s1_prod_q[i]);
               s2_res_d[i*W +: W] = s1_mask_q[i] ? lane_out[W-1:0] : '0;
               s2_ovf_d[i]        = s1_mask_q[i] & lane_out[W];
            end
         end
      end
   end

   // Sticky overflow: a delivery in the same cycle as a clear wins.
   always_comb begin
      sticky_d = clr_sticky ? '0 : sticky_q;
      if (s2_vld_q && out_ready) begin
         sticky_d = sticky_d | s2_ovf_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_op_q   <= ALU_ADD;
         s1_mask_q <= '0;
         s1_op1_q  <= '0;
         s1_op2_q  <= '0;
         s1_op3_q  <= '0;
         s1_prod_q <= '0;
         s2_vld_q  <= 1'b0;
         s2_res_q  <= '0;
         s2_ovf_q  <= '0;
         s2_mask_q <= '0;
         sticky_q  <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_op_q   <= s1_op_d;
         s1_mask_q <= s1_mask_d;
         s1_op1_q  <= s1_op1_d;
         s1_op2_q  <= s1_op2_d;
         s1_op3_q  <= s1_op3_d;
         s1_prod_q <= s1_prod_d;
         s2_vld_q  <= s2_vld_d;
         s2_res_q  <= s2_res_d;
         s2_ovf_q  <= s2_ovf_d;
         s2_mask_q <= s2_mask_d;
         sticky_q  <= sticky_d;
      end
   end

   assign out_valid     = s2_vld_q;
   assign out_result    = s2_res_q;
   assign out_overflow  = s2_ovf_q;
   assign out_lane_mask = s2_mask_q;
   assign ovf_sticky    = sticky_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
module tb_simd_alu_pipe;
   import warp_pkg::*;

   localparam int W = 32;
   localparam int L = 4;

`ifdef SIMD_ALU_SAT_EN
   localparam logic [W-1:0] ADD_OVF_RES = 32'h7FFF_FFFF;
   localparam logic [W-1:0] MUL_OVF_RES = 32'h7FFF_FFFF;
   localparam logic [W-1:0] FMA_OVF_RES = 32'h7FFF_FFFF;
`else
   localparam logic [W-1:0] ADD_OVF_RES = 32'h8000_0000;
   localparam logic [W-1:0] MUL_OVF_RES = 32'h0000_0000;
   localparam logic [W-1:0] FMA_OVF_RES = 32'h8000_0000;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   alu_opcode_e    in_opcode = ALU_ADD;
   logic [L-1:0]   in_lane_mask = '0;
   logic [L*W-1:0] in_op1 = '0;
   logic [L*W-1:0] in_op2 = '0;
   logic [L*W-1:0] in_op3 = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [L*W-1:0] out_result;
   logic [L-1:0]   out_overflow;
   logic [L-1:0]   out_lane_mask;
   logic [L-1:0]   ovf_sticky;
   logic           clr_sticky = 1'b0;

   simd_alu_pipe #(.DATA_WIDTH(W), .NUM_LANES(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_lane_mask(in_lane_mask), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_overflow(out_overflow), .out_lane_mask(out_lane_mask),
      .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [L*W-1:0] res;
      logic [L-1:0]   ovf;
      logic [L-1:0]   mask;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic logic [L*W-1:0] pk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                         input logic [W-1:0] a2, input logic [W-1:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   // Monitor: pops the scoreboard on each delivery and checks hold stability during stalls.
   logic           stall_seen = 1'b0;
   logic [L*W-1:0] held_res;
   logic [L-1:0]   held_ovf, held_mask;
   logic           saw_block = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_seen = 1'b0;
      end else begin
         if (in_valid && !in_ready) saw_block = 1'b1;
         if (stall_seen && out_valid) begin
            check("stall_stable_result", out_result, held_res);
            check("stall_stable_ovf", out_overflow, held_ovf);
            check("stall_stable_mask", out_lane_mask, held_mask);
         end
         if (out_valid && !out_ready) begin
            stall_seen = 1'b1;
            held_res   = out_result;
            held_ovf   = out_overflow;
            held_mask  = out_lane_mask;
         end else begin
            stall_seen = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_beat: got beat %h want none", out_result);
            end else begin
               cur = sb.pop_front();
               check("result", out_result, cur.res);
               check("overflow", out_overflow, cur.ovf);
               check("lane_mask", out_lane_mask, cur.mask);
            end
         end
      end
   end

   // Drive one beat from the posedge+1 phase; returns at posedge+1 after acceptance.
   task automatic send(input alu_opcode_e op, input logic [L-1:0] m,
                       input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic [L*W-1:0] c,
                       input logic [L*W-1:0] er, input logic [L-1:0] eo);
      int k;
      in_opcode    = op;
      in_lane_mask = m;
      in_op1       = a;
      in_op2       = b;
      in_op3       = c;
      in_valid     = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL accept_timeout: got in_ready 0 want 1");
      end else begin
         sb.push_back('{res: er, ovf: eo, mask: m});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_result", out_result, '0);
      check("rst_sticky", ovf_sticky, '0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1'b1);

      // ADD overflow on every lane, with latency check
      send(ALU_ADD, 4'b1111, {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, '0, {4{ADD_OVF_RES}}, 4'b1111);
      check("lat_cycle1_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      check("lat_cycle2_valid", out_valid, 1'b1);
      drain();

      // MUL: 2^16*2^16 overflows, -3*4 does not
      send(ALU_MUL, 4'b1111, pk(32'h0001_0000, 32'hFFFF_FFFD, 32'd0, 32'd7),
           pk(32'h0001_0000, 32'd4, 32'd9, 32'd6), '0,
           pk(MUL_OVF_RES, 32'hFFFF_FFF4, 32'd0, 32'd42), 4'b0001);

      // FMA: 0x4000_0000*2+0 overflows; 3*5-20 = -5
      send(ALU_FMA, 4'b1111, pk(32'h4000_0000, 32'd3, 32'd0, 32'd0),
           pk(32'd2, 32'd5, 32'd0, 32'd0), pk(32'd0, 32'hFFFF_FFEC, 32'd0, 32'd0),
           pk(FMA_OVF_RES, 32'hFFFF_FFFB, 32'd0, 32'd0), 4'b0001);

      // MAX with mask 0101
      send(ALU_MAX, 4'b0101, {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFB}}, '0,
           pk(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0), 4'b0000);

      // RELU and an unused opcode
      send(ALU_RELU, 4'b1111, pk(32'd5, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000), '0, '0,
           pk(32'd5, 32'd0, 32'h7FFF_FFFF, 32'd0), 4'b0000);
      send(ALU_NOP, 4'b1111, {4{32'h7FFF_FFFF}}, {4{32'h0000_0001}}, '0, '0, 4'b0000);
      drain();

      // Back-to-back stream of 6 beats with out_ready low for cycles 3-5
      saw_block = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               send(ALU_ADD, 4'b1111,
                    pk(k*16+0, k*16+1, k*16+2, k*16+3), {4{32'd1}}, '0,
                    pk(k*16+1, k*16+2, k*16+3, k*16+4), 4'b0000);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("stream_in_ready_dropped", saw_block, 1'b1);

      // Sticky overflow
      clr_sticky = 1'b1;
      @(posedge clk);
      #1 clr_sticky = 1'b0;
      check("sticky_cleared_pre", ovf_sticky, 4'b0000);
      send(ALU_ADD, 4'b1111, pk(32'd1, 32'd1, 32'h7FFF_FFFF, 32'd1), {4{32'd1}}, '0,
           pk(32'd2, 32'd2, ADD_OVF_RES, 32'd2), 4'b0100);
      drain();
      check("sticky_lane2", ovf_sticky, 4'b0100);
      clr_sticky = 1'b1;
      @(posedge clk);
      #1 clr_sticky = 1'b0;
      check("sticky_cleared", ovf_sticky, 4'b0000);

      // Reset mid-stall drops the in-flight beat
      out_ready = 1'b0;
      send(ALU_ADD, 4'b1111, {4{32'd1}}, {4{32'd1}}, '0, {4{32'd2}}, 4'b0000);
      for (int k = 0; k < 10 && !out_valid; k++) begin
         @(posedge clk);
         #1;
      end
      check("stall_before_reset_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_out_result", out_result, '0);
      check("async_rst_out_mask", out_lane_mask, '0);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_reset_no_output", out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
